// File: rtl/shift_transmitter_4bit_pkg.sv
// Shared definitions for the parallel-in / serial-out transmitter.
//   WIDTH_DEFAULT : default word length in bits
//   state_t       : FSM state encoding (IDLE / SHIFT / DONE)
package shift_transmitter_4bit_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_transmitter_4bit_bit_counter.sv
// Bit counter for the transmitter.
// It counts the bits shifted out of the current word.
//   i_clk  : system clock, rising edge
//   i_rst  : asynchronous active-high reset, clears the count
//   i_en   : advance the count by one
//   i_clr  : synchronous clear; wins over i_en
//   o_tc   : terminal count, high while the count equals WIDTH-1
// The count returns to 0 after the terminal count instead of running past it.
// This keeps the count within 0..WIDTH-1 for any WIDTH, including
// widths that are not a power of two.
module shift_transmitter_4bit_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  logic [CW-1:0] r_cnt;

  assign o_tc = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (o_tc) r_cnt <= '0;
      else      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/shift_transmitter_4bit.sv
// Parallel-in / serial-out transmitter.
// It loads a WIDTH-bit word and sends it MSB first, one bit per enabled clock.
//   clock     : system clock, rising edge
//   reset     : asynchronous active-high reset, clears all state
//   clkEN     : clock-enable tick; state advances only on enabled edges
//   start     : request to send ParIn; sampled only in IDLE
//   ParIn     : word to transmit; captured on the accepting edge only
//   SerOut    : serial data, MSB first; 0 outside SHIFT
//   ShEn      : shift strobe for the receiver; high only in SHIFT
//   Busy      : high in SHIFT and DONE
//   Done      : high for the single enabled period spent in DONE
//   dbg_state : current FSM state, for observation
// Handshake: the controller raises start while Busy is low. The word is taken
// on the first enabled edge seen in IDLE. A start raised during SHIFT or DONE
// is dropped, not queued. Done marks the one enabled period after the last bit.
module shift_transmitter_4bit
  import shift_transmitter_4bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clkEN,
  input  logic             start,
  input  logic [WIDTH-1:0] ParIn,
  output logic             SerOut,
  output logic             ShEn,
  output logic             Busy,
  output logic             Done,
  output state_t           dbg_state
);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_last_bit;

  // The counter is cleared when a word is accepted.
  // It then advances on each enabled edge spent in SHIFT.
  assign w_cnt_clr = clkEN & (r_state == S_IDLE) & start;
  assign w_cnt_en  = clkEN & (r_state == S_SHIFT);

  shift_transmitter_4bit_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .i_clk (clock),
    .i_rst (reset),
    .i_en  (w_cnt_en),
    .i_clr (w_cnt_clr),
    .o_tc  (w_last_bit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
    end else if (clkEN) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shreg <= ParIn;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // The receiver samples SerOut on this same edge.
          // The next bit therefore appears only after this shift.
          r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
          if (w_last_bit) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Moore outputs are decoded only from registered state.
  // They hold steady whenever clkEN is low.
  assign SerOut    = r_shreg[WIDTH-1] & (r_state == S_SHIFT);
  assign ShEn      = (r_state == S_SHIFT);
  assign Busy      = (r_state != S_IDLE);
  assign Done      = (r_state == S_DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_shift_transmitter_4bit.sv
module tb_shift_transmitter_4bit;
  import shift_transmitter_4bit_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clock;
  logic       reset;
  logic       clkEN;
  logic       start;
  logic [3:0] par_in;
  logic       ser_out, sh_en, busy, done;
  state_t     dbg_state;

  logic       start8;
  logic [7:0] par8;
  logic       ser_out8, sh_en8, busy8, done8;
  state_t     dbg_state8;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  shift_transmitter_4bit #(.WIDTH(4)) u_dut (
    .clock (clock), .reset (reset), .clkEN (clkEN), .start (start),
    .ParIn (par_in), .SerOut (ser_out), .ShEn (sh_en), .Busy (busy),
    .Done (done), .dbg_state (dbg_state)
  );

  shift_transmitter_4bit #(.WIDTH(8)) u_dut8 (
    .clock (clock), .reset (reset), .clkEN (clkEN), .start (start8),
    .ParIn (par8), .SerOut (ser_out8), .ShEn (sh_en8), .Busy (busy8),
    .Done (done8), .dbg_state (dbg_state8)
  );

  // ---------------- scoreboard state ----------------
  logic [0:0] exp_q[$];
  logic [0:0] exp8_q[$];
  logic [3:0] exp_word_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cnt_shen = 0;
  int         cnt_done = 0;
  int         cnt_busy8 = 0;
  int         en_mode = 0;
  int         ph = 0;
  logic       was_en;
  logic [3:0] rx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Receiver model: serial-in shift register, shifting on ShEn with the shared clkEN.
  always @(posedge clock or posedge reset) begin
    if (reset)              rx <= 4'h0;
    else if (clkEN && sh_en) rx <= {rx[2:0], ser_out};
  end

  // ---------------- monitors ----------------
  always @(negedge clock) begin
    logic [0:0] b;
    logic [3:0] w;
    if (!reset) begin
      if (sh_en) begin
        cnt_shen++;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL ser_out_extra: actual bit %0b with no word expected at %0t", ser_out, $time);
        end else begin
          check("ser_out", 32'(ser_out), 32'(exp_q[0]));
          if (clkEN) b = exp_q.pop_front();
        end
      end
      if (done) begin
        cnt_done++;
        if (clkEN) begin
          if (exp_word_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL done_extra: actual rx %0h with no word expected at %0t", rx, $time);
          end else begin
            w = exp_word_q.pop_front();
            check("rx_word", 32'(rx), 32'(w));
          end
        end
      end
      if (sh_en8) begin
        if (exp8_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL ser_out8_extra: actual bit %0b with no word expected at %0t", ser_out8, $time);
        end else begin
          check("ser_out8", 32'(ser_out8), 32'(exp8_q[0]));
          if (clkEN) b = exp8_q.pop_front();
        end
      end
      if (busy8 && clkEN) cnt_busy8++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    was_en = clkEN;
    #1;
    ph = (ph == 2) ? 0 : ph + 1;
    clkEN = (en_mode == 0) ? 1'b1 : (ph == 0);
  endtask

  task automatic en_step();
    do step(); while (!was_en);
  endtask

  task automatic push_word(input logic [3:0] d);
    for (int i = 3; i >= 0; i--) exp_q.push_back(d[i]);
    exp_word_q.push_back(d);
  endtask

  // Caller guarantees the DUT is in IDLE.
  task automatic send_word(input logic [3:0] d);
    par_in = d;
    start  = 1'b1;
    push_word(d);
    en_step();
    start  = 1'b0;
  endtask

  task automatic clear_counts();
    cnt_shen = 0;
    cnt_done = 0;
    cnt_busy8 = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; clkEN = 1'b1; start = 1'b0; par_in = 4'h0;
    start8 = 1'b0; par8 = 8'h00;
    #3;
    check("rst_ser_out", 32'(ser_out), 0);
    check("rst_sh_en",   32'(sh_en),   0);
    check("rst_busy",    32'(busy),    0);
    check("rst_done",    32'(done),    0);
    check("rst_state",   32'(dbg_state), 32'(S_IDLE));
    check("rst_state8",  32'(dbg_state8), 32'(S_IDLE));
    check("rst_busy8",   32'(busy8 | done8 | sh_en8), 0);
    repeat (2) step();
    reset = 1'b0;
    step();

    // Test 1: reset after 2 bits of 1011, then a full word.
    send_word(4'b1011);
    en_step();
    en_step();
    check("mid_state", 32'(dbg_state), 32'(S_SHIFT));
    #2 reset = 1'b1;
    #1;
    check("mid_rst_outs", 32'({ser_out, sh_en, busy, done}), 0);
    check("mid_rst_state", 32'(dbg_state), 32'(S_IDLE));
    exp_q.delete();
    exp_word_q.delete();
    reset = 1'b0;
    step();
    check("post_rst_state", 32'(dbg_state), 32'(S_IDLE));
    check("post_rst_busy", 32'(busy), 0);
    send_word(4'b1011);
    repeat (5) en_step();

    // Test 2: continuous enable, 1011 -> 4 shift clocks and 1 done clock.
    clear_counts();
    send_word(4'b1011);
    repeat (5) en_step();
    step();
    check("t2_shen_clks", 32'(cnt_shen), 4);
    check("t2_done_clks", 32'(cnt_done), 1);

    // Test 3: enable every 3rd clock, 0110 -> 12 shift clocks and 3 done clocks.
    en_mode = 1;
    en_step();
    clear_counts();
    send_word(4'b0110);
    repeat (5) en_step();
    repeat (3) step();
    check("t3_shen_clks", 32'(cnt_shen), 12);
    check("t3_done_clks", 32'(cnt_done), 3);
    en_mode = 0;
    step();

    // Test 4: start held high, A then 5, back to back.
    clear_counts();
    par_in = 4'hA; start = 1'b1; push_word(4'hA);
    en_step();
    par_in = 4'h5; push_word(4'h5);
    repeat (5) en_step();
    check("t4_state_idle", 32'(dbg_state), 32'(S_IDLE));
    en_step();
    start = 1'b0;
    check("t4_second_accept", 32'(dbg_state), 32'(S_SHIFT));
    repeat (5) en_step();
    step();
    check("t4_done_count", 32'(cnt_done), 2);

    // Test 5: start and ParIn disturbed during SHIFT/DONE.
    clear_counts();
    send_word(4'b1011);
    start = 1'b1; par_in = 4'b0100;
    repeat (5) en_step();
    start = 1'b0;
    repeat (8) en_step();
    check("t5_done_count", 32'(cnt_done), 1);
    check("t5_shen_clks", 32'(cnt_shen), 4);
    check("t5_busy", 32'(busy), 0);

    // Test 6: 8-bit instance, 0x81.
    clear_counts();
    par8 = 8'h81; start8 = 1'b1;
    for (int i = 7; i >= 0; i--) exp8_q.push_back(par8[i]);
    en_step();
    start8 = 1'b0;
    repeat (10) en_step();
    check("t6_busy8_edges", 32'(cnt_busy8), 9);
    check("t6_state8", 32'(dbg_state8), 32'(S_IDLE));

    // ---------------- report ----------------
    step();
    check("left_bits", 32'(exp_q.size()), 0);
    check("left_words", 32'(exp_word_q.size()), 0);
    check("left_bits8", 32'(exp8_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: actual timeout required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
